line_fill_buffer: RTL and testbench
===================================

LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 Parameter WORD_W, 32, data word width in bits.
REQ-002 Parameter ADDR_W, 32, byte address width; line = 8 words, word index = addr[4:2].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 miss_valid  input  1  refill request; miss_addr  input  ADDR_W  missing word address (critical word).
REQ-006 miss_ready  output  1  high exactly when state is IDLE.
REQ-007 mem_req  output  1  read request; mem_addr  output  ADDR_W  {line base, critical word index, 2'b00}.
REQ-008 mem_gnt  input  1  request accepted; mem_rvalid  input  1, mem_rdata  input  WORD_W  return beat.
REQ-009 st_valid  input  1, st_word_en  input  8 (one-hot word enable, bit n = word n), st_data  input  WORD_W: store merge.
REQ-010 fill_valid  output  1, fill_line  output  8*WORD_W (word n at bits [n*WORD_W +: WORD_W]), fill_addr  output  ADDR_W (line base, addr[4:0]=0).
REQ-011 fill_ready  input  1  consumer accepts line.
REQ-012 crit_valid  output  1, crit_data  output  WORD_W  early critical-word forward.

Function
REQ-013 States IDLE, REQ, FILL, DONE; IDLE->REQ when miss_valid && miss_ready, latching miss_addr.
REQ-014 REQ: mem_req=1, mem_addr stable; REQ->FILL on cycle mem_gnt=1; mem_req deasserts next cycle.
REQ-015 mem_req asserts the cycle after miss acceptance; no mem_req outside REQ.
REQ-016 FILL: memory returns 8 beats in wrap order starting at critical index c: c, c+1, ... mod 8; 3-bit beat pointer wraps 7->0.
REQ-017 Each mem_rvalid in FILL writes mem_rdata to word at beat pointer, then pointer increments; beat counter counts 0..7.
REQ-018 Cycle after 8th beat: state DONE, fill_valid=1; fill_line and fill_addr stable while fill_valid.
REQ-019 DONE->IDLE on fill_valid && fill_ready; miss_ready high the following cycle; same-cycle new miss not accepted.
REQ-020 mem_rvalid outside FILL ignored; mem_gnt outside REQ ignored.
REQ-021 st_valid in FILL or DONE writes st_data into every word whose st_word_en bit is set and sets that word's owned bit.
REQ-022 Mem beats to owned words do not overwrite data; pointer/counter still advance.
REQ-023 Store and mem beat to same word same cycle: store wins.
REQ-024 st_word_en=8'h00 or st_valid in IDLE/REQ: no effect; owned mask clears on DONE->IDLE.

Reset
REQ-025 rst_n low asynchronously: state IDLE, miss_ready=1, mem_req=0, fill_valid=0, crit_valid=0, mem_addr/fill_addr/crit_data=0, line storage and owned mask=0, counters=0.
REQ-026 Reset mid-FILL abandons refill; beats arriving after release are ignored (state IDLE).

Configuration
REQ-027 Macro LFB_CRIT_WORD_EN defined: crit_valid=1 combinationally on first beat in FILL (counter=0, mem_rvalid=1), crit_data=mem_rdata that cycle, else 0.
REQ-028 Macro undefined: crit_valid and crit_data tied 0; all other behaviour identical.

Verification
REQ-029 miss_addr=0x1000_0008, gnt after 2 cycles, beats 0xA2..0xA7,0xA0,0xA1 -> mem_addr=0x1000_0008, fill_addr=0x1000_0000, word n = 0xA0+n, fill_valid cycle after 8th beat.
REQ-030 Same miss, st_valid with st_word_en=8'h10, st_data=0xDEAD before beat for word 4 -> fill_line word 4 = 0xDEAD, others from memory.
REQ-031 Store word_en=8'h04 same cycle as beat for word 2 -> word 2 = store data.
REQ-032 fill_ready held low 5 cycles -> fill_valid and fill_line stable 5 cycles, miss_ready low; miss_ready=1 cycle after handshake.
REQ-033 rst_n low after 3 beats, released, 5 stray beats -> no fill_valid, miss_ready=1, mem_req=0.
REQ-034 LFB_CRIT_WORD_EN defined, miss_addr=0x2000_001C, first beat 0x55 -> crit_valid=1 one cycle, crit_data=0x55; undefined -> crit_valid stays 0.

Source files
------------

// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches an 8-word line in critical-word-first wrap order
// and merges in-flight stores. Define LFB_CRIT_WORD_EN for early critical-word forwarding.
module line_fill_buffer #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_valid,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  miss_ready,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [WORD_W-1:0]     mem_rdata,
    input  logic                  st_valid,
    input  logic [7:0]            st_word_en,
    input  logic [WORD_W-1:0]     st_data,
    output logic                  fill_valid,
    output logic [8*WORD_W-1:0]   fill_line,
    output logic [ADDR_W-1:0]     fill_addr,
    input  logic                  fill_ready,
    output logic                  crit_valid,
    output logic [WORD_W-1:0]     crit_data
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          ptr;
    logic [2:0]          cnt;
    logic [7:0]          owned;
    logic [WORD_W-1:0]   line_q [8];

    logic accept;
    logic beat;
    logic store_ok;
    logic release_line;

    assign accept       = miss_valid && (state == IDLE);
    assign beat         = mem_rvalid && (state == FILL);
    assign store_ok     = st_valid && ((state == FILL) || (state == DONE));
    assign release_line = (state == DONE) && fill_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        miss_ready = 1'b0;
        mem_req    = 1'b0;
        fill_valid = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = FILL;
            end
            FILL: begin
                if (mem_rvalid && (cnt == 3'd7)) state_nxt = DONE;
            end
            DONE: begin
                fill_valid = 1'b1;
                if (fill_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte offset is dropped at capture so mem_addr is the register itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ptr    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            addr_q <= miss_addr & ~ADDR_W'(3);
            ptr    <= miss_addr[4:2];
            cnt    <= '0;
        end else if (beat) begin
            ptr    <= ptr + 3'd1;
            cnt    <= cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            owned <= '0;
        else if (release_line) owned <= '0;
        else if (store_ok)     owned <= owned | st_word_en;
    end

    // NOTE: the line storage is reset explicitly because a refill abandoned by
    // reset must not leave stale words visible; this keeps it out of RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 8; n++) line_q[n] <= '0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (store_ok && st_word_en[n])
                    line_q[n] <= st_data;
                else if (beat && (ptr == 3'(n)) && !owned[n])
                    line_q[n] <= mem_rdata;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign fill_line[g*WORD_W +: WORD_W] = line_q[g];
    end

    assign mem_addr  = addr_q;
    assign fill_addr = {addr_q[ADDR_W-1:5], 5'b0};

`ifdef LFB_CRIT_WORD_EN
    assign crit_valid = beat && (cnt == 3'd0);
    assign crit_data  = crit_valid ? mem_rdata : '0;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed self-checking bench for line_fill_buffer: table-driven refill plus
// hand-written store-merge, back-pressure, critical-word and reset sequences.
module tb_line_fill_buffer;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
`ifdef LFB_CRIT_WORD_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                miss_valid = 1'b0;
    logic [ADDR_W-1:0]   miss_addr = '0;
    logic                miss_ready;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_gnt = 1'b0;
    logic                mem_rvalid = 1'b0;
    logic [WORD_W-1:0]   mem_rdata = '0;
    logic                st_valid = 1'b0;
    logic [7:0]          st_word_en = '0;
    logic [WORD_W-1:0]   st_data = '0;
    logic                fill_valid;
    logic [8*WORD_W-1:0] fill_line;
    logic [ADDR_W-1:0]   fill_addr;
    logic                fill_ready = 1'b0;
    logic                crit_valid;
    logic [WORD_W-1:0]   crit_data;

    line_fill_buffer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .st_valid(st_valid), .st_word_en(st_word_en), .st_data(st_data),
        .fill_valid(fill_valid), .fill_line(fill_line), .fill_addr(fill_addr),
        .fill_ready(fill_ready), .crit_valid(crit_valid), .crit_data(crit_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        mv;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        fr;
        logic        crit;
        logic        exp_mr;
        logic        exp_req;
        logic        exp_fv;
    } vec_t;

    vec_t vecs[13];
    logic [WORD_W-1:0] exp_w [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8*WORD_W-1:0] pack_exp();
        logic [8*WORD_W-1:0] r;
        for (int n = 0; n < 8; n++) r[n*WORD_W +: WORD_W] = exp_w[n];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        miss_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        st_valid = 1'b0; st_word_en = '0; st_data = '0; fill_ready = 1'b0;
    endtask

    initial begin
        logic [8*WORD_W-1:0] held;
        int w;

        // Refill of 0x1000_0008: grant two cycles after mem_req, stray rvalid in REQ,
        // stray gnt in FILL, beats in wrap order from word 2.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hBAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++)
            vecs[3+k] = '{1'b0, (k == 1), 1'b1, 32'hA0 + ((2 + k) % 8), 1'b0,
                          (k == 0), 1'b0, 1'b0, (k == 7)};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        #2;
        check("rst_miss_ready", 256'(miss_ready), 256'(1));
        check("rst_mem_req",    256'(mem_req),    256'(0));
        check("rst_fill_valid", 256'(fill_valid), 256'(0));
        check("rst_crit_valid", 256'(crit_valid), 256'(0));
        check("rst_mem_addr",   256'(mem_addr),   256'(0));
        check("rst_fill_addr",  256'(fill_addr),  256'(0));
        check("rst_fill_line",  256'(fill_line),  256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Scenario A: table-driven basic refill
        for (int n = 0; n < 8; n++) exp_w[n] = 32'hA0 + 32'(n);
        miss_addr = 32'h1000_0008;
        for (int i = 0; i < 13; i++) begin
            miss_valid = vecs[i].mv; mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rv;
            mem_rdata = vecs[i].rdata; fill_ready = vecs[i].fr;
            #1;
            check($sformatf("a%0d_crit_valid", i), 256'(crit_valid), 256'(CRIT_EN && vecs[i].crit));
            check($sformatf("a%0d_crit_data", i), 256'(crit_data),
                  256'((CRIT_EN && vecs[i].crit) ? vecs[i].rdata : 32'h0));
            step();
            check($sformatf("a%0d_miss_ready", i), 256'(miss_ready), 256'(vecs[i].exp_mr));
            check($sformatf("a%0d_mem_req", i),    256'(mem_req),    256'(vecs[i].exp_req));
            check($sformatf("a%0d_fill_valid", i), 256'(fill_valid), 256'(vecs[i].exp_fv));
            if (vecs[i].exp_req)
                check($sformatf("a%0d_mem_addr", i), 256'(mem_addr), 256'(32'h1000_0008));
            if (vecs[i].exp_fv) begin
                check($sformatf("a%0d_fill_addr", i), 256'(fill_addr), 256'(32'h1000_0000));
                check($sformatf("a%0d_fill_line", i), 256'(fill_line), 256'(pack_exp()));
            end
        end
        clear_inputs();

        // Scenario B: store merge, store-wins collision, ignored stores, back-pressure
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        check("b_mem_req", 256'(mem_req), 256'(1));
        st_valid = 1'b1; st_word_en = 8'hFF; st_data = 32'h1111;  // store in REQ: no effect
        step();
        st_valid = 1'b0; st_word_en = '0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("b_req_drop", 256'(mem_req), 256'(0));
        for (int k = 0; k < 8; k++) begin
            w = (2 + k) % 8;
            mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(w);
            st_valid = 1'b0; st_word_en = '0;
            if (k == 0) begin st_valid = 1'b1; st_word_en = 8'h04; st_data = 32'hBEEF; end
            if (k == 1) begin st_valid = 1'b1; st_word_en = 8'h10; st_data = 32'hDEAD; end
            if (k == 3) begin st_valid = 1'b1; st_word_en = 8'h00; st_data = 32'h7777; end
            step();
        end
        clear_inputs();
        exp_w[2] = 32'hBEEF;
        exp_w[4] = 32'hDEAD;
        check("b_fill_valid", 256'(fill_valid), 256'(1));
        check("b_fill_line",  256'(fill_line),  256'(pack_exp()));
        held = fill_line;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("b_hold%0d_fv", c),   256'(fill_valid), 256'(1));
            check($sformatf("b_hold%0d_line", c), 256'(fill_line),  256'(held));
            check($sformatf("b_hold%0d_mr", c),   256'(miss_ready), 256'(0));
        end
        fill_ready = 1'b1; miss_valid = 1'b1;  // same-cycle miss must not be taken
        step();
        fill_ready = 1'b0; miss_valid = 1'b0;
        check("b_hs_miss_ready", 256'(miss_ready), 256'(1));
        check("b_hs_fill_valid", 256'(fill_valid), 256'(0));
        step();
        check("b_no_same_cycle_miss", 256'(mem_req), 256'(0));

        // Scenario C: critical word 7 at 0x2000_001C; owned mask must have cleared
        miss_addr = 32'h2000_001C; miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        check("c_mem_addr", 256'(mem_addr), 256'(32'h2000_001C));
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int n = 0; n < 8; n++) exp_w[n] = 32'h60 + 32'(n);
        exp_w[7] = 32'h55;
        for (int k = 0; k < 8; k++) begin
            w = (7 + k) % 8;
            mem_rvalid = 1'b1; mem_rdata = exp_w[w];
            #1;
            check($sformatf("c%0d_crit_valid", k), 256'(crit_valid), 256'(CRIT_EN && (k == 0)));
            check($sformatf("c%0d_crit_data", k),  256'(crit_data),
                  256'((CRIT_EN && (k == 0)) ? 32'h55 : 32'h0));
            step();
        end
        mem_rvalid = 1'b0;
        check("c_fill_valid", 256'(fill_valid), 256'(1));
        check("c_fill_addr",  256'(fill_addr),  256'(32'h2000_0000));
        check("c_fill_line",  256'(fill_line),  256'(pack_exp()));
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;

        // Scenario D: reset mid-FILL, then stray beats
        miss_addr = 32'h3000_0004; miss_valid = 1'b1;
        step();
        miss_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hC0 + 32'(k);
            step();
        end
        mem_rvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("d_rst_miss_ready", 256'(miss_ready), 256'(1));
        check("d_rst_mem_req",    256'(mem_req),    256'(0));
        check("d_rst_mem_addr",   256'(mem_addr),   256'(0));
        check("d_rst_fill_line",  256'(fill_line),  256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hE0 + 32'(k);
            step();
            check($sformatf("d%0d_fill_valid", k), 256'(fill_valid), 256'(0));
            check($sformatf("d%0d_miss_ready", k), 256'(miss_ready), 256'(1));
            check($sformatf("d%0d_mem_req", k),    256'(mem_req),    256'(0));
        end
        mem_rvalid = 1'b0;
        check("d_fill_line", 256'(fill_line), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
